// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module  : serial_adder_pkg
// Brief   : Shared constants and state type for the bit-serial adder.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  // Operand width used when the instantiating design does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_fa.sv
//------------------------------------------------------------------------------
// Module  : fullAdder
// Brief   : 1-bit full adder cell, the per-bit datapath of the serial adder.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fullAdder (
  output logic cout,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic cin
);

  // Sum is the parity of the three inputs; carry is generate or propagate.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : fullAdder

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module  : serial_adder
// Brief   : Bit-serial adder. Captures a, b, cin on an accepted start, adds one
//           bit per clock LSB-first through a single full-adder cell, then
//           pulses done with {cout,sum} = a + b + cin.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only needs to represent 0..WIDTH.
  localparam int               CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_fa_s;
  logic             w_fa_co;

  // Single bit-step datapath: LSBs of both operand shifters plus running carry.
  fullAdder u_fa (
    .cout (w_fa_co),
    .s    (w_fa_s),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q)
  );

  // Next-state and datapath update selection for every register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        // Result fills from the MSB side so the first (LSB) bit ends at bit 0.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {w_fa_s, sum_q[WIDTH-1:1]};
        carry_d = w_fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // cout is only updated here so it stays stable outside the add.
          cout_d  = w_fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // All state held in one clocked process with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module  : tb_serial_adder
// Brief   : Directed self-checking bench for serial_adder (WIDTH 8 and 16).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [7:0]  sum;
  logic        cout;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;

  int total;
  int bad;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit add and wait (bounded) for done; reports latency and busy cycles.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         output int lat, output int bcnt,
                         output logic [7:0] s, output logic co);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    s = sum; co = cout;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    start16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy, done, sum, cout);
    end
    total++;
    if ({busy16, done16, sum16, cout16} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs16: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy16, done16, sum16, cout16);
    end
    // start held through release: first edge with reset low accepts.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_accept: got busy=%b, want 1", busy);
    end
    // AA+55+1 = 0x100
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_result: got done=%b sum=%h cout=%b, want 1 00 1",
               done, sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] va [6] = '{8'hFF, 8'h5A, 8'h00, 8'h7F, 8'hFF, 8'h12};
    logic [7:0] vb [6] = '{8'h01, 8'hA5, 8'h00, 8'h80, 8'hFF, 8'h34};
    logic       vc [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] es [6] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h46};
    logic       ec [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bcnt;
    logic [7:0] s;
    logic co;
    for (int i = 0; i < 6; i++) begin
      run_add(va[i], vb[i], vc[i], lat, bcnt, s, co);
      total++;
      if (s !== es[i] || co !== ec[i]) begin
        bad++;
        $display("FAIL basic_result[%0d]: got sum=%h cout=%b, want sum=%h cout=%b",
                 i, s, co, es[i], ec[i]);
      end
      total++;
      if (lat !== 8 || bcnt !== 8) begin
        bad++;
        $display("FAIL basic_timing[%0d]: got latency=%0d busy_cycles=%0d, want 8 8",
                 i, lat, bcnt);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL basic_done_pulse[%0d]: got done=%b busy=%b after pulse, want 0 0",
                 i, done, busy);
      end
    end
  endtask

  // Sum 8'h46 is left from the last basic vector.
  task automatic test_hold();
    int errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = 8'(i * 37 + 5); b = 8'(i * 11 + 200); cin = i[0]; start = 1'b0;
      @(posedge clk); #1;
      if (sum !== 8'h46 || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hold_result: got %0d bad cycles (last sum=%h done=%b), want 0 (sum=46 done=0)",
               errs, sum, done);
    end
  endtask

  // Inputs and start toggled during ADD must not disturb the captured add.
  task automatic test_ignore();
    int lat = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    while (!done && lat < 30) begin
      @(negedge clk);
      a = ~a; b = b + 8'h1D; cin = ~cin; start = ~start;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat !== 8 || sum !== 8'h46 || cout !== 1'b0) begin
      bad++;
      $display("FAIL ignore_inputs: got latency=%0d sum=%h cout=%b, want 8 46 0", lat, sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone = 0, prev = -1, errs = 0;
    @(negedge clk);
    a = 8'd3; b = 8'd4; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (sum !== 8'd7 || cout !== 1'b0) errs++;
        if (prev >= 0 && (i - prev) != 10) errs++;
        prev = i;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (ndone !== 3 || errs !== 0) begin
      bad++;
      $display("FAIL back_to_back: got dones=%0d errors=%0d, want 3 0", ndone, errs);
    end
    // Drain the in-flight add (accepted on edge 31).
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_add: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               busy, done, sum, cout);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_random8();
    int lat, bcnt, errs = 0;
    logic [7:0] s, ra, rb;
    logic co, rc;
    logic [8:0] exp;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_add(ra, rb, rc, lat, bcnt, s, co);
      if ({co, s} !== exp || lat != 8) begin
        errs++;
        $display("FAIL random8[%0d]: %h+%h+%b got %b_%h lat=%0d, want %h lat=8",
                 i, ra, rb, rc, co, s, lat, exp);
      end
      @(posedge clk); #1;
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_width16();
    logic [15:0] va [4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'hABCD};
    logic [15:0] vb [4] = '{16'h0001, 16'h4321, 16'h8000, 16'h0000};
    logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [16:0] ex [4] = '{17'h10000, 17'h05556, 17'h10001, 17'h0ABCD};
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a16 = va[i]; b16 = vb[i]; cin16 = vc[i]; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if ({cout16, sum16} !== ex[i] || lat !== 16) begin
        bad++;
        $display("FAIL width16[%0d]: got %b_%h lat=%0d, want %h lat=16",
                 i, cout16, sum16, lat, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  first operand; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  second operand; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while an addition is in progress (ADD state).
REQ-009 Port: done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 Port: sum  output  WIDTH  result bits; held stable until the next accepted start.
REQ-011 Port: cout  output  1  final carry-out; held with sum.
REQ-012 One clock; reset is synchronous and active-high.

Function
REQ-013 Result SHALL satisfy {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), for the captured operands.
REQ-014 FSM states: IDLE, ADD, DONE; no other reachable states.
REQ-015 IDLE with start=1 at an edge: capture a, b into shift registers, carry register <= cin, bit counter <= 0, go to ADD.
REQ-016 IDLE with start=0: remain in IDLE; registers unchanged.
REQ-017 ADD, each edge: one bit-step using the 1-bit full-adder on (A[0], B[0], carry); its sum bit shifts into the result MSB, result shifts right, A and B shift right, carry <= full-adder carry, counter increments.
REQ-018 ADD: after exactly WIDTH bit-steps, go to DONE; on that same edge sum holds the full result and cout the final carry.
REQ-019 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-020 Latency: done high in the cycle beginning WIDTH edges after the edge that accepted start; next start accepted no earlier than WIDTH+2 edges after the previous accept.
REQ-021 busy=1 exactly in ADD; busy=0 in IDLE and DONE.
REQ-022 start asserted in ADD or DONE is ignored, not queued; a, b, cin changes outside the accepting edge have no effect.
REQ-023 sum/cout SHALL NOT change except during ADD; in IDLE they hold the last completed result.
REQ-024 Counter width ceil(log2(WIDTH+1)) bits; no wrap-around reachable.

Reset
REQ-025 reset=1 at an edge overrides all other inputs: state <= IDLE, busy=0, done=0, sum=0, cout=0, shift registers, carry and counter <= 0.
REQ-026 reset mid-ADD or in DONE aborts the operation; no done pulse is produced for the aborted addition.
REQ-027 start asserted in the same cycle as reset is ignored; first acceptance is possible on the first edge with reset=0.

Structure
REQ-028 State encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) live as localparams in the shared package serial_adder_pkg, which also holds WIDTH's default.
REQ-029 Exactly one sub-module: the team's existing 1-bit fullAdder cell (ports cout, s, a, b, cin), instantiated once as the bit-step datapath.
REQ-030 All registers in one clocked process; next-state and full-adder wiring combinational.

Verification
REQ-031 WIDTH=8: a=8'hFF, b=8'h01, cin=0, start pulse -> busy high 8 cycles, done pulse 8 edges after accept, sum=8'h00, cout=1.
REQ-032 WIDTH=8: a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1; a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
REQ-033 start held high continuously with a=3,b=4,cin=0 -> accepts every WIDTH+2 edges; each done shows sum=7, cout=0; start during busy never restarts.
REQ-034 reset asserted at bit-step 4 of a=8'hF0+b=8'h0F -> next cycle state IDLE, busy=0, sum=0, cout=0, no done pulse.
REQ-035 After a completed add (sum=8'h46), change a, b freely with start=0 for 20 cycles -> sum stays 8'h46, done stays 0.
REQ-036 Randomised 1000 operand pairs at WIDTH=8 and WIDTH=16 -> every done matches a+b+cin reference model.
